// File: rtl/tpmem_ctrl.sv
// ---------------------------------------------------------------------------
// tpmem_ctrl
//
// Sequencer for the 8x8 transpose memory that sits between the row-wise and
// column-wise 1-D DCT stages. The 64-bit rows travel straight from the
// upstream stage into the memory; this block only decides when a row may be
// written, when the memory is draining columns, and how many blocks of the
// frame have been completed. It owns the memory's reset so that the memory's
// internal row/column counter always stays in lockstep with this sequencer.
//
// Block timing: 8 accepted row writes (FILL) followed by exactly 8 drain
// cycles (DRAIN). Column k appears on the memory output one cycle after drain
// count k, because the memory output is registered.
//
// Ports
//   i_clk          clock
//   i_Reset        synchronous, active-high reset
//   i_start        frame start pulse, sampled only in IDLE
//   i_num_blocks   blocks in the frame, sampled with i_start
//   i_abort        abandons the current frame from any state
//   i_valid        upstream row valid
//   o_ready        row accepted when i_valid & o_ready
//   i_ds_space     downstream can absorb 8 consecutive column beats
//   o_tp_enable    memory write enable
//   o_tp_rst_n     active-low reset to the memory (registered)
//   o_drain        memory is in its column-read phase
//   o_row_idx      next row slot to be written
//   o_block_cnt    blocks fully drained in this frame
//   o_busy         sequencer is not idle
//   o_frame_done   one-cycle pulse at end of frame
// ---------------------------------------------------------------------------
module tpmem_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_Reset,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_blocks,
  input  logic             i_abort,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_ds_space,
  output logic             o_tp_enable,
  output logic             o_tp_rst_n,
  output logic             o_drain,
  output logic [2:0]       o_row_idx,
  output logic [CNT_W-1:0] o_block_cnt,
  output logic             o_busy,
  output logic             o_frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       row_idx, row_idx_nxt;
  logic [2:0]       drain_cnt, drain_cnt_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic [CNT_W-1:0] block_cnt, block_cnt_nxt;
  logic             frame_done;
  logic             tp_rst_n;
  logic             accept;

  // Row 7 completes the block and immediately commits the memory to an
  // 8-cycle drain, so it is held back until downstream can take all 8 beats.
  assign o_ready     = (state == FILL) && ((row_idx != 3'd7) || i_ds_space);
  assign accept      = i_valid && o_ready;
  assign o_tp_enable = accept;
  assign o_drain     = (state == DRAIN);
  assign o_busy      = (state != IDLE);
  assign o_row_idx   = row_idx;
  assign o_block_cnt = block_cnt;
  assign o_frame_done = frame_done;
  assign o_tp_rst_n  = tp_rst_n;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    row_idx_nxt   = row_idx;
    drain_cnt_nxt = drain_cnt;
    remaining_nxt = remaining;
    block_cnt_nxt = block_cnt;

    if (i_abort) begin
      // Abort beats everything, including a start in the same cycle.
      state_nxt     = IDLE;
      row_idx_nxt   = 3'd0;
      drain_cnt_nxt = 3'd0;
      remaining_nxt = '0;
      block_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_num_blocks != '0) begin
              state_nxt     = FILL;
              remaining_nxt = i_num_blocks;
              block_cnt_nxt = '0;
              row_idx_nxt   = 3'd0;
            end else begin
              state_nxt = DONE;
            end
          end
        end

        FILL: begin
          if (accept) begin
            // 3-bit index wraps 7 -> 0 on its own.
            row_idx_nxt = row_idx + 3'd1;
            if (row_idx == 3'd7) begin
              drain_cnt_nxt = 3'd0;
              state_nxt     = DRAIN;
            end
          end
        end

        DRAIN: begin
          // The memory advances through its columns by itself; this counter
          // only tracks where it is so the block can be closed out.
          drain_cnt_nxt = drain_cnt + 3'd1;
          if (drain_cnt == 3'd7) begin
            block_cnt_nxt = block_cnt + 1'b1;
            remaining_nxt = remaining - 1'b1;
            state_nxt     = (remaining == CNT_W'(1)) ? DONE : FILL;
          end
        end

        DONE: begin
          state_nxt = IDLE;
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_Reset) begin
      state      <= IDLE;
      row_idx    <= 3'd0;
      drain_cnt  <= 3'd0;
      remaining  <= '0;
      block_cnt  <= '0;
      frame_done <= 1'b0;
      tp_rst_n   <= 1'b0;
    end else begin
      state      <= state_nxt;
      row_idx    <= row_idx_nxt;
      drain_cnt  <= drain_cnt_nxt;
      remaining  <= remaining_nxt;
      block_cnt  <= block_cnt_nxt;
      // High exactly for the single cycle spent in DONE.
      frame_done <= (state_nxt == DONE);
      // Memory reset follows every abort by one cycle, which throws away
      // partial rows and any drain in flight and rewinds its counter.
      tp_rst_n   <= ~i_abort;
    end
  end

endmodule
